// File: rtl/dram_arbiter.sv
// dram_arbiter: merges the I-cache and D-cache burst DRAM ports onto one
// banked-memory port. Reads from both clients interleave freely and are
// tracked in a small outstanding-read table so that response beats can be
// steered back to their requester by address. A write burst locks the port
// to its owner until all BURST_LEN beats have been accepted.
//
// Build option: define ARB_DCACHE_PRIO_EN to give the D-cache fixed priority
// on every idle conflict; otherwise the two clients alternate (round robin).
module dram_arbiter #(
    parameter int TRACK_DEPTH = 4,
    parameter int BURST_LEN   = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_dram_addr,
    input  logic        i_dram_read,
    input  logic        i_dram_write,
    input  logic [63:0] i_dram_wdata,
    output logic        i_dram_ready,
    output logic [31:0] i_dram_raddr,
    output logic [63:0] i_dram_rdata,
    output logic        i_dram_rvalid,

    input  logic [31:0] d_dram_addr,
    input  logic        d_dram_read,
    input  logic        d_dram_write,
    input  logic [63:0] d_dram_wdata,
    output logic        d_dram_ready,
    output logic [31:0] d_dram_raddr,
    output logic [63:0] d_dram_rdata,
    output logic        d_dram_rvalid,

    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_raddr,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid,

    output logic        err_unmatched
);

    localparam int            CW       = $clog2(BURST_LEN + 1);
    localparam int            IW       = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          wown_q, wown_d;        // write-burst owner, 1 = D-cache
    logic [CW-1:0] wbeat_q, wbeat_d;      // write beats accepted so far

    // Outstanding-read tracker
    logic [TRACK_DEPTH-1:0] tv_q, tv_d;   // entry valid
    logic [TRACK_DEPTH-1:0] to_q, to_d;   // entry owner, 1 = D-cache
    logic [31:0]            ta_q [TRACK_DEPTH];
    logic [31:0]            ta_d [TRACK_DEPTH];
    logic [CW-1:0]          tc_q [TRACK_DEPTH];
    logic [CW-1:0]          tc_d [TRACK_DEPTH];

    logic                   err_q;

    logic [TRACK_DEPTH-1:0] hit_i_vec, hit_d_vec, match_vec;
    logic                   full, hit_i, hit_d, any_match;
    logic [IW-1:0]          alloc_idx;
    logic                   rsp_owner;

    logic                   i_ok, d_ok;
    logic                   pref_d;       // 1 = D-cache wins the next idle conflict
    logic                   sel_d;        // 1 = D-cache is the selected client
    logic                   sel_wr;
    logic                   gnt;
    logic                   idle_acc;
    logic                   alloc_en;
    logic [31:0]            sel_addr;
    logic [63:0]            sel_wdata;

    // Per-entry address comparators: client request vs. tracker, response vs. tracker
    for (genvar gi = 0; gi < TRACK_DEPTH; gi++) begin : g_cmp
        assign hit_i_vec[gi] = tv_q[gi] && (ta_q[gi] == i_dram_addr);
        assign hit_d_vec[gi] = tv_q[gi] && (ta_q[gi] == d_dram_addr);
        assign match_vec[gi] = tv_q[gi] && (ta_q[gi] == bmem_raddr);
    end

    assign full      = &tv_q;
    assign hit_i     = |hit_i_vec;
    assign hit_d     = |hit_d_vec;
    assign any_match = |match_vec;

    // Lowest free tracker slot and owner of the entry matching the response
    always_comb begin
        alloc_idx = '0;
        rsp_owner = 1'b0;
        for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
            if (!tv_q[k]) begin
                alloc_idx = IW'(k);
            end
            if (match_vec[k]) begin
                rsp_owner = to_q[k];
            end
        end
    end

    // A client is acceptable when the memory is ready and, for reads, the
    // tracker has room and the line is not already in flight
    assign i_ok = bmem_ready && (i_dram_write || (i_dram_read && !full && !hit_i));
    assign d_ok = bmem_ready && (d_dram_write || (d_dram_read && !full && !hit_d));

`ifdef ARB_DCACHE_PRIO_EN
    assign pref_d = 1'b1;
`else
    logic rr_q, rr_d;

    assign pref_d = rr_q;

    // Round-robin pointer moves away from whoever just had a command accepted
    always_comb begin
        rr_d = rr_q;
        if (idle_acc) begin
            rr_d = !sel_d;
        end
    end

    // Pointer register; reset favours the D-cache
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Arbitration FSM: client selection, grant and next state
    always_comb begin
        state_d  = state_q;
        wown_d   = wown_q;
        wbeat_d  = wbeat_q;
        sel_d    = 1'b0;
        sel_wr   = 1'b0;
        gnt      = 1'b0;
        idle_acc = 1'b0;
        alloc_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ok && d_ok) begin
                    sel_d = pref_d;
                end else begin
                    sel_d = d_ok;
                end
                sel_wr = sel_d ? d_dram_write : i_dram_write;
                gnt    = i_ok || d_ok;
                if (gnt) begin
                    idle_acc = 1'b1;
                    if (sel_wr) begin
                        // A one-beat burst completes on its first beat
                        if (BURST_LEN > 1) begin
                            state_d = WBURST;
                            wown_d  = sel_d;
                            wbeat_d = CW'(1);
                        end
                    end else begin
                        alloc_en = 1'b1;
                    end
                end
            end
            WBURST: begin
                sel_d  = wown_q;
                sel_wr = sel_d ? d_dram_write : i_dram_write;
                gnt    = sel_wr && bmem_ready;
                if (gnt) begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (wbeat_q == LAST_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            gnt      = 1'b0;
            idle_acc = 1'b0;
            alloc_en = 1'b0;
        end
    end

    // Passthrough of the selected client's request fields
    always_comb begin
        sel_addr  = sel_d ? d_dram_addr  : i_dram_addr;
        sel_wdata = sel_d ? d_dram_wdata : i_dram_wdata;
    end

    assign bmem_addr    = sel_addr;
    assign bmem_wdata   = sel_wdata;
    assign bmem_read    = gnt && !sel_wr;
    assign bmem_write   = gnt && sel_wr;
    assign i_dram_ready = gnt && !sel_d;
    assign d_dram_ready = gnt && sel_d;

    // Responses are broadcast; only the owning client sees rvalid
    assign i_dram_raddr  = bmem_raddr;
    assign i_dram_rdata  = bmem_rdata;
    assign d_dram_raddr  = bmem_raddr;
    assign d_dram_rdata  = bmem_rdata;
    assign i_dram_rvalid = !rst && bmem_rvalid && any_match && !rsp_owner;
    assign d_dram_rvalid = !rst && bmem_rvalid && any_match && rsp_owner;
    assign err_unmatched = err_q;

    // Tracker next state: count response beats, free after the last one,
    // allocate newly accepted reads (never into a slot freed this cycle)
    always_comb begin
        tv_d = tv_q;
        to_d = to_q;
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            ta_d[k] = ta_q[k];
            tc_d[k] = tc_q[k];
            if (bmem_rvalid && match_vec[k]) begin
                tc_d[k] = tc_q[k] + 1'b1;
                if (tc_q[k] == LAST_CNT) begin
                    tv_d[k] = 1'b0;
                end
            end
        end
        if (alloc_en) begin
            tv_d[alloc_idx] = 1'b1;
            to_d[alloc_idx] = sel_d;
            ta_d[alloc_idx] = sel_addr;
            tc_d[alloc_idx] = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wown_q  <= 1'b0;
            wbeat_q <= '0;
            tv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wown_q  <= wown_d;
            wbeat_q <= wbeat_d;
            tv_q    <= tv_d;
            err_q   <= err_q || (bmem_rvalid && !any_match);
        end
    end

    // Tracker payload registers; qualified by tv_q so no reset needed
    always_ff @(posedge clk) begin
        to_q <= to_d;
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            ta_q[k] <= ta_d[k];
            tc_q[k] <= tc_d[k];
        end
    end

endmodule
